riscv_fetch_unit: RTL and testbench

- Parametrised instruction-fetch front end for the next-generation (pipelined) RISC-V core. Replaces the single-cycle core's direct PC to Instr connection.
- Issues pipelined requests on a valid/ready instruction-memory interface and buffers in-order responses in a DEPTH-entry prefetch FIFO.
- Presents {pc, instr} pairs to decode through a valid/ready handshake.
- Supports branch/jump redirect, with discard of stale in-flight responses.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/riscv_fetch_fifo.sv | 66 ++++++
 rtl/riscv_fetch_unit.sv | 126 ++++++++++++
 tb/tb_riscv_fetch_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the pipelined RISC-V front end.
// Holds the default datapath width and reset vector, the instruction word
// width, the sequential PC step and the fetch FSM state encoding.
package riscv_pkg;

    localparam int unsigned    XLEN_DEF     = 32;
    localparam logic [31:0]    RESET_PC_DEF = 32'h0000_0000;
    localparam int unsigned    INSTR_W      = 32;
    localparam int unsigned    PC_STEP      = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Prefetch buffer: DEPTH x WIDTH synchronous FIFO with flush.
// Ports: clk, reset (async, active-low), flush (clears contents, wins over
// push/pop), push/wdata (write tail), pop (drop head), rdata (head entry),
// count (occupancy), full, empty.
module riscv_fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is cleared on reset so the head reads as zero out of reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem <= '{default: '0};
        end else if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch front end: issues pipelined fetch requests, buffers
// in-order responses with their PCs and hands {pc, instr} to decode.
// Ports: clk, reset (async, active-low), fetch_en (allow new requests),
// imem_req_valid/ready/addr (request channel), imem_rsp_valid/data (response
// channel, in order, never stalled), redirect_valid/pc (taken branch/jump,
// flushes the front end), inst_valid/ready/pc/data (decode channel).
module riscv_fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEF,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_en,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [XLEN-1:0]    inst_pc,
    output logic [INSTR_W-1:0] inst_data
);

    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam int unsigned SW = CW + 1;
    localparam int unsigned EW = XLEN + INSTR_W;

    fetch_state_e    state_q;
    fetch_state_e    state_d;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] rsp_pc_q;
    logic [XLEN-1:0] redirect_base;
    logic [CW-1:0]   outstanding_q;
    logic [CW-1:0]   outstanding_d;
    logic [CW-1:0]   drop_q;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_push;
    logic            fifo_pop;
    logic            req_fire;
    logic [EW-1:0]   fifo_rdata;
    logic            unused_redirect_lo;

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: RUN simply follows fetch_en
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (fetch_en)  state_d = RUN;
            RUN:  if (!fetch_en) state_d = IDLE;
        endcase
    end

    // Buffered plus in-flight never exceeds DEPTH, so responses always fit
    assign imem_req_valid = (state_q == RUN)
                          & ((SW'(fifo_count) + SW'(outstanding_q)) < SW'(DEPTH))
                          & ~redirect_valid;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign outstanding_d  = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);

    assign redirect_base      = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lo = ^redirect_pc[1:0];

    assign fifo_push  = imem_rsp_valid & (drop_q == '0) & ~redirect_valid;
    assign inst_valid = ~fifo_empty & ~redirect_valid;
    assign fifo_pop   = inst_valid & inst_ready;

    // PC tracking and stale-response accounting; redirect overrides all
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            if (redirect_valid) begin
                fetch_pc_q <= redirect_base;
                rsp_pc_q   <= redirect_base;
                drop_q     <= outstanding_d;
            end else begin
                if (req_fire) fetch_pc_q <= fetch_pc_q + XLEN'(PC_STEP);
                if (imem_rsp_valid) begin
                    if (drop_q != '0) drop_q   <= drop_q - CW'(1);
                    else              rsp_pc_q <= rsp_pc_q + XLEN'(PC_STEP);
                end
            end
        end
    end

    riscv_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({rsp_pc_q, imem_rsp_data}),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign inst_pc   = fifo_rdata[EW-1:INSTR_W];
    assign inst_data = fifo_rdata[INSTR_W-1:0];

    // A response into a full buffer means the issue throttle was broken
    assert property (@(posedge clk) disable iff (!reset) !(imem_rsp_valid && fifo_full));

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Directed bench for riscv_fetch_unit with a 1-cycle in-order memory model
// and a decode-side scoreboard.
module tb_riscv_fetch_unit;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_en = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] sb[$];
    logic [31:0] pend[$];
    logic [31:0] req_log[$];
    int          req_cnt = 0;
    int          pop_cyc[$];
    int          cyc = 0;
    bit          rsp_hold = 1'b0;

    riscv_fetch_unit #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_pc        (inst_pc),
        .inst_data      (inst_data)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Record request handshakes (sampled mid-cycle, away from the edge)
    initial forever begin
        @(negedge clk);
        if (reset && imem_req_valid && imem_req_ready) begin
            pend.push_back(imem_req_addr);
            req_log.push_back(imem_req_addr);
            req_cnt++;
        end
    end

    // Memory returns each accepted request one cycle later, data = addr ^ KEY
    initial forever begin
        logic [31:0] a;
        @(posedge clk);
        #2;
        if (!reset) begin
            pend.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end else if (!rsp_hold && pend.size() > 0) begin
            a = pend.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = a ^ KEY;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    // Decode-side monitor: every accepted instruction must match the scoreboard head
    initial forever begin
        logic [63:0] e;
        @(negedge clk);
        if (reset && inst_valid && inst_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_inst: got pc 0x%0h data 0x%0h, expected none", inst_pc, inst_data);
            end else begin
                e = sb.pop_front();
                check("inst_pc", inst_pc, e[63:32]);
                check("inst_data", inst_data, e[31:0]);
            end
            pop_cyc.push_back(cyc);
        end
    end

    task automatic expect_seq(input logic [31:0] base, input int n);
        logic [31:0] pc;
        for (int i = 0; i < n; i++) begin
            pc = base + 32'(4 * i);
            sb.push_back({pc, pc ^ KEY});
        end
    endtask

    task automatic run_until_reqs(input int n, input string name);
        int t = 0;
        while (req_cnt < n && t < 200) begin
            tick();
            t++;
        end
        imem_req_ready = 1'b0;
        check(name, 32'(req_cnt), 32'(n));
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (sb.size() != 0 && t < 100) begin
            tick();
            t++;
        end
        repeat (4) tick();
        check(name, 32'(sb.size()), 32'd0);
    endtask

    function automatic logic [31:0] log_at(input int i);
        if (i < req_log.size()) return req_log[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic do_reset();
        reset          = 1'b0;
        fetch_en       = 1'b0;
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        rsp_hold       = 1'b0;
        sb.delete();
        repeat (2) tick();
        req_log.delete();
        req_cnt = 0;
        pop_cyc.delete();
        reset = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values, asserted before any clock edge
        #1 reset = 1'b0;
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, 32'h0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_inst_data", inst_data, 32'h0);

        // 1: streaming fetch, decode always ready
        do_reset();
        fetch_en = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b1;
        expect_seq(32'h0, 8);
        run_until_reqs(8, "t1_reqs");
        fetch_en = 1'b0;
        check("t1_addr0", log_at(0), 32'h0);
        check("t1_addr7", log_at(7), 32'h1C);
        drain("t1_drain");
        check("t1_pops", 32'(pop_cyc.size()), 32'd8);
        if (pop_cyc.size() == 8) check("t1_gapfree", 32'(pop_cyc[7] - pop_cyc[0]), 32'd7);

        // 2: decode stalled, issue throttles at DEPTH
        do_reset();
        fetch_en = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b0;
        repeat (12) tick();
        check("t2_req_cnt", 32'(req_cnt), 32'd4);
        check("t2_req_valid", 32'(imem_req_valid), 32'd0);
        check("t2_count", 32'(dut.fifo_count), 32'd4);
        check("t2_head_valid", 32'(inst_valid), 32'd1);
        check("t2_head_pc", inst_pc, 32'h0);
        expect_seq(32'h0, 6);
        inst_ready = 1'b1;
        run_until_reqs(6, "t2_reqs");
        fetch_en = 1'b0;
        check("t2_resume_addr", log_at(4), 32'h10);
        drain("t2_drain");

        // 3: memory stall holds the request stable
        do_reset();
        fetch_en = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b1;
        expect_seq(32'h0, 4);
        run_until_reqs(2, "t3_first");
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", 32'(imem_req_valid), 32'd1);
            check("t3_hold_addr", imem_req_addr, 32'h8);
            tick();
        end
        imem_req_ready = 1'b1;
        run_until_reqs(4, "t3_reqs");
        fetch_en = 1'b0;
        check("t3_addr2", log_at(2), 32'h8);
        drain("t3_drain");

        // 4: redirect with one buffered entry and two in flight
        do_reset();
        fetch_en = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b0;
        run_until_reqs(1, "t4_first");
        tick();
        rsp_hold = 1'b1; imem_req_ready = 1'b1;
        run_until_reqs(3, "t4_more");
        check("t4_count", 32'(dut.fifo_count), 32'd1);
        check("t4_head_pc", inst_pc, 32'h0);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        #1;
        check("t4_redir_inst_valid", 32'(inst_valid), 32'd0);
        check("t4_redir_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        check("t4_flushed", 32'(inst_valid), 32'd0);
        check("t4_drop", 32'(dut.drop_q), 32'd2);
        check("t4_new_addr", imem_req_addr, 32'h100);
        expect_seq(32'h100, 2);
        rsp_hold = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b1;
        run_until_reqs(5, "t4_reqs");
        fetch_en = 1'b0;
        check("t4_addr3", log_at(3), 32'h100);
        drain("t4_drain");

        // 5: redirect to unaligned target coinciding with a response
        do_reset();
        rsp_hold = 1'b1; fetch_en = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b1;
        run_until_reqs(2, "t5_first");
        rsp_hold = 1'b0; imem_req_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        tick();
        redirect_valid = 1'b0;
        check("t5_new_addr", imem_req_addr, 32'h100);
        check("t5_drop", 32'(dut.drop_q), 32'd1);
        expect_seq(32'h100, 2);
        run_until_reqs(2, "t5_no_redir_req");
        imem_req_ready = 1'b1;
        run_until_reqs(4, "t5_reqs");
        fetch_en = 1'b0;
        check("t5_addr2", log_at(2), 32'h100);
        check("t5_addr3", log_at(3), 32'h104);
        drain("t5_drain");

        // 6: asynchronous reset in the middle of a cycle
        do_reset();
        fetch_en = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b0;
        run_until_reqs(3, "t6_first");
        tick(); tick();
        check("t6_pre_valid", 32'(inst_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("t6_req_valid", 32'(imem_req_valid), 32'd0);
        check("t6_req_addr", imem_req_addr, 32'h0);
        check("t6_inst_valid", 32'(inst_valid), 32'd0);
        check("t6_inst_pc", inst_pc, 32'h0);
        check("t6_inst_data", inst_data, 32'h0);
        check("t6_count", 32'(dut.fifo_count), 32'd0);
        tick(); tick();
        sb.delete(); req_log.delete(); req_cnt = 0;
        reset = 1'b1;
        fetch_en = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b1;
        check("t6_no_stale", 32'(inst_valid), 32'd0);
        expect_seq(32'h0, 2);
        run_until_reqs(2, "t6_reqs");
        fetch_en = 1'b0;
        check("t6_addr0", log_at(0), 32'h0);
        drain("t6_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
